// File: rtl/clock_gen_pkg.sv
// Shared types and constants for the clock divider bank.
// Holds the divide-ratio type, the per-channel state encoding and the minimum ratio.
package clock_gen_pkg;

   localparam int DIV_W   = 16;
   localparam int DIV_MIN = 2;

   typedef logic [DIV_W-1:0] div_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } ch_state_e;

endpackage

// File: rtl/clock_div_channel.sv
// One divider channel: counter, shadow config, state tracking and registered outputs.
// A pending config is applied at the channel's wrap, or on the next cycle while disabled.
module clock_div_channel
   import clock_gen_pkg::*;
#(
   parameter int DIV_W     = 16,
   parameter int DIV_RESET = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_cfg_we,
   input  logic [DIV_W-1:0] i_cfg_div,
   input  logic [DIV_W-1:0] i_cfg_phase,
   output logic             o_clk_div,
   output logic             o_tick,
   output logic             o_locked,
   output logic             o_pending,
   output ch_state_e        o_state
);

   localparam logic [DIV_W-1:0] DIV_MIN_W = DIV_W'(DIV_MIN);
   localparam logic [DIV_W-1:0] DIV_RST_W = DIV_W'(DIV_RESET);

   logic [DIV_W-1:0] cnt, div, shadow_div, shadow_phase;
   logic [DIV_W-1:0] cfg_div_clamped, cfg_phase_mod, cnt_next, div_next;
   logic [DIV_W:0]   rem;
   logic             wrap, apply, pending_next, locked_next, clk_next;
   ch_state_e        state_next;

   // Phase modulo ratio by restoring shift-subtract, so no divider is needed.
   always_comb begin
      cfg_div_clamped = (i_cfg_div < DIV_MIN_W) ? DIV_MIN_W : i_cfg_div;
      rem = '0;
      for (int i = DIV_W - 1; i >= 0; i--) begin
         rem = {rem[DIV_W-1:0], i_cfg_phase[i]};
         if (rem >= {1'b0, cfg_div_clamped}) begin
            rem = rem - {1'b0, cfg_div_clamped};
         end
      end
      cfg_phase_mod = rem[DIV_W-1:0];
   end

   always_comb begin
      wrap         = i_en && (cnt == div - 1'b1);
      apply        = o_pending && (!i_en || wrap);
      div_next     = apply ? shadow_div : div;
      pending_next = (o_pending && !apply) || i_cfg_we;
      cnt_next     = cnt + 1'b1;
      locked_next  = o_locked;
      if (!i_en) begin
         cnt_next    = '0;
         locked_next = 1'b0;
      end else if (wrap) begin
         cnt_next    = o_pending ? shadow_phase : '0;
         locked_next = !o_pending;
      end
      clk_next = i_en && (cnt_next < (div_next >> 1));
      if (!i_en) begin
         state_next = IDLE;
      end else if (pending_next) begin
         state_next = PEND;
      end else begin
         state_next = RUN;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt          <= '0;
         div          <= DIV_RST_W;
         shadow_div   <= DIV_RST_W;
         shadow_phase <= '0;
         o_pending    <= 1'b0;
         o_clk_div    <= 1'b0;
         o_tick       <= 1'b0;
         o_locked     <= 1'b0;
         o_state      <= IDLE;
      end else begin
         cnt       <= cnt_next;
         div       <= div_next;
         o_pending <= pending_next;
         o_clk_div <= clk_next;
         o_tick    <= clk_next && !o_clk_div;
         o_locked  <= locked_next;
         o_state   <= state_next;
         if (i_cfg_we) begin
            shadow_div   <= cfg_div_clamped;
            shadow_phase <= cfg_phase_mod;
         end
      end
   end

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel clock-enable/divider bank with a shared config port.
// Handshake: a config transfers when i_cfg_valid && o_cfg_ready; ready is low while the target channel holds a pending config.
module clock_divider_bank
   import clock_gen_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int DIV_W     = 16,
   parameter int DIV_RESET = 2,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_cfg_valid,
   output logic                  o_cfg_ready,
   input  logic [CH_W-1:0]       i_cfg_ch,
   input  logic [DIV_W-1:0]      i_cfg_div,
   input  logic [DIV_W-1:0]      i_cfg_phase,
   input  logic [NUM_CH-1:0]     i_ch_en,
   output logic [NUM_CH-1:0]     o_clk_div,
   output logic [NUM_CH-1:0]     o_tick,
   output logic [NUM_CH-1:0]     o_locked,
   output logic [2*NUM_CH-1:0]   o_dbg_state
);

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] cfg_we;
   ch_state_e         ch_state [NUM_CH];

   always_comb begin
      o_cfg_ready = 1'b0;
      if (int'(i_cfg_ch) < NUM_CH) begin
         o_cfg_ready = !pending[i_cfg_ch];
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign cfg_we[c] = i_cfg_valid && o_cfg_ready && (i_cfg_ch == CH_W'(c));
      assign o_dbg_state[2*c +: 2] = ch_state[c];

      clock_div_channel #(
         .DIV_W     (DIV_W),
         .DIV_RESET (DIV_RESET)
      ) u_ch (
         .i_clk       (i_clk),
         .i_rst       (i_rst),
         .i_en        (i_ch_en[c]),
         .i_cfg_we    (cfg_we[c]),
         .i_cfg_div   (i_cfg_div),
         .i_cfg_phase (i_cfg_phase),
         .o_clk_div   (o_clk_div[c]),
         .o_tick      (o_tick[c]),
         .o_locked    (o_locked[c]),
         .o_pending   (pending[c]),
         .o_state     (ch_state[c])
      );
   end

endmodule
